// File: rtl/cheri_dmem_bridge.sv
// CHERIoT data-port bridge: req/gnt/rvalid to data SRAM plus 1-bit tag SRAM.
// Optional range check: define CHERI_DMEM_RANGE_CHK_EN.
module cheri_dmem_bridge #(
  parameter logic [31:0] AddrBase    = 32'h2000_0000,
  parameter int unsigned Depth       = 16384,
  parameter int unsigned AW          = $clog2(Depth),
  parameter int unsigned StallCycles = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          data_req_i,
  output logic          data_gnt_o,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic          data_is_cap_i,
  input  logic [31:0]   data_addr_i,
  input  logic [32:0]   data_wdata_i,
  output logic          data_rvalid_o,
  output logic [32:0]   data_rdata_o,
  output logic          data_err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          tag_req_o,
  output logic          tag_we_o,
  output logic [AW-1:0] tag_addr_o,
  output logic          tag_wdata_o,
  input  logic          tag_rdata_i,
  output logic          init_done_o
);

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StStall
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [3:0]    stall_q, stall_d;
  logic          init_done_q, init_done_d;

  logic          rvalid_q;
  logic          is_cap_q;
  logic          we_q;
  logic          err_q;

  logic [31:0]   offset;
  logic [AW-1:0] waddr;
  logic          acc_err;
  logic          gnt;
  logic          acc;
  logic          tag_wval;
  logic          rd_ok;
  logic          unused_offset;

  assign offset = data_addr_i - AddrBase;
  assign waddr  = offset[AW+1:2];
  assign unused_offset = ^{offset[31:AW+2], offset[1:0]};

`ifdef CHERI_DMEM_RANGE_CHK_EN
  localparam logic [32:0] Limit =
    {1'b0, AddrBase} + (33'(Depth) << 2);

  // Out-of-window accesses are granted but never reach the RAMs.
  always_comb begin
    acc_err = (data_addr_i < AddrBase) |
              ({1'b0, data_addr_i} >= Limit);
  end
`else
  assign acc_err = 1'b0;
`endif

  assign gnt = (state_q == StIdle) & data_req_i;
  assign acc = gnt & ~acc_err;

  // A tag survives only a full-word capability store with tag set.
  assign tag_wval = data_is_cap_i & data_wdata_i[32] &
                    (data_be_i == 4'hF);

  assign data_gnt_o  = gnt;
  assign init_done_o = init_done_q;

  // RAM strobes: tag clear sweep during init, else granted accesses.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    tag_req_o   = 1'b0;
    tag_we_o    = 1'b0;
    tag_addr_o  = '0;
    tag_wdata_o = 1'b0;
    if (state_q == StInit) begin
      tag_req_o  = 1'b1;
      tag_we_o   = 1'b1;
      tag_addr_o = cnt_q;
    end else if (acc) begin
      mem_req_o   = 1'b1;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = waddr;
      mem_wdata_o = data_wdata_i[31:0];
      tag_req_o   = 1'b1;
      tag_we_o    = data_we_i;
      tag_addr_o  = waddr;
      tag_wdata_o = tag_wval;
    end
  end

  // Next-state: init sweep, idle granting, post-grant stall countdown.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_d     = stall_q;
    init_done_d = init_done_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(Depth - 1)) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end
      end
      StIdle: begin
        if (gnt && (StallCycles != 0)) begin
          state_d = StStall;
          stall_d = 4'(StallCycles);
        end
      end
      StStall: begin
        if (stall_q <= 4'd1) begin
          state_d = StIdle;
        end else begin
          stall_d = stall_q - 4'd1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // FSM and init/stall counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      stall_q     <= 4'h0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_q     <= stall_d;
      init_done_q <= init_done_d;
    end
  end

  // Per-grant response context; rvalid follows each grant by one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      is_cap_q <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= gnt;
      if (gnt) begin
        is_cap_q <= data_is_cap_i;
        we_q     <= data_we_i;
        err_q    <= acc_err;
      end
    end
  end

  assign rd_ok         = rvalid_q & ~we_q & ~err_q;
  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = rvalid_q & err_q;
  assign data_rdata_o  = rd_ok ?
    {tag_rdata_i & is_cap_q, mem_rdata_i} : 33'h0;

endmodule
